// File: rtl/reg_status_file_pkg.sv
// reg_status_file_pkg: shared widths, tag encoding and types for the register status table.
// No ports; imported by the interface, the per-register cell and the top.
package reg_status_file_pkg;
    localparam int REG_NUM        = 32;
    localparam int DATA_WIDTH     = 32;
    localparam int LOCK_WIDTH     = 4;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int COUNT_WIDTH    = 6;

    typedef logic [DATA_WIDTH-1:0]     data_t;
    typedef logic [LOCK_WIDTH-1:0]     lock_t;
    typedef logic [REG_ADDR_WIDTH-1:0] addr_t;
    typedef logic [COUNT_WIDTH-1:0]    count_t;

    // MSB set with all other bits clear marks "no producer" (ready / CDB idle).
    localparam lock_t REG_NO_LOCK = lock_t'(1) << (LOCK_WIDTH - 1);

    function automatic logic is_live(lock_t tag);
        return tag != REG_NO_LOCK;
    endfunction
endpackage

// File: rtl/reg_status_file_if.sv
// reg_status_file_if: decoder/CDB-facing bus of the register status table.
// master: decoder + CDB side (drives read addresses, lock claims, broadcasts).
// slave:  register status table (returns read data/locks and locked_count).
interface reg_status_file_if;
    import reg_status_file_pkg::*;

    addr_t  rd_addr1;
    addr_t  rd_addr2;
    data_t  rd_data1;
    data_t  rd_data2;
    lock_t  rd_lock1;
    lock_t  rd_lock2;
    logic   lock_enable;
    addr_t  lock_addr;
    lock_t  lock_tag;
    lock_t  cdb_in_index_alu;
    data_t  cdb_in_result_alu;
    lock_t  cdb_in_index_lsm;
    data_t  cdb_in_result_lsm;
    count_t locked_count;

    modport master (
        output rd_addr1, rd_addr2, lock_enable, lock_addr, lock_tag,
               cdb_in_index_alu, cdb_in_result_alu, cdb_in_index_lsm, cdb_in_result_lsm,
        input  rd_data1, rd_data2, rd_lock1, rd_lock2, locked_count
    );

    modport slave (
        input  rd_addr1, rd_addr2, lock_enable, lock_addr, lock_tag,
               cdb_in_index_alu, cdb_in_result_alu, cdb_in_index_lsm, cdb_in_result_lsm,
        output rd_data1, rd_data2, rd_lock1, rd_lock2, locked_count
    );
endinterface

// File: rtl/reg_status_file_cell.sv
// reg_status_file_cell: one architectural register (data + lock tag) with CDB capture and lock set.
// Ports: clk, rst_n (async active-low); lock_set_i/lock_tag_i claim this register;
// alu_*/lsm_* CDB broadcasts; data_o/lock_o stored state; lock_d_o next-state lock.
module reg_status_file_cell
    import reg_status_file_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  lock_set_i,
    input  lock_t lock_tag_i,
    input  lock_t alu_tag_i,
    input  data_t alu_data_i,
    input  lock_t lsm_tag_i,
    input  data_t lsm_data_i,
    output data_t data_o,
    output lock_t lock_o,
    output lock_t lock_d_o
);
    data_t data_q, data_d;
    lock_t lock_q, lock_d;
    logic  hit_alu, hit_lsm;

    // ALU wins if both ports ever carry the same live tag. A same-cycle lock
    // claim overrides the release but the captured value is still written.
    always_comb begin
        hit_alu = is_live(alu_tag_i) && lock_q == alu_tag_i;
        hit_lsm = is_live(lsm_tag_i) && lock_q == lsm_tag_i;
        data_d  = hit_alu ? alu_data_i : hit_lsm ? lsm_data_i : data_q;
        lock_d  = lock_set_i ? lock_tag_i : (hit_alu || hit_lsm) ? REG_NO_LOCK : lock_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            lock_q <= REG_NO_LOCK;
        end else begin
            data_q <= data_d;
            lock_q <= lock_d;
        end
    end

    assign data_o   = data_q;
    assign lock_o   = lock_q;
    assign lock_d_o = lock_d;
endmodule

// File: rtl/reg_status_file.sv
// reg_status_file: architectural register file with per-register lock tags for the Tomasulo core.
// Ports: clk, rst_n (async active-low); bus_s (slave modport): two bypassed read ports,
// destination lock claim, ALU/LSM CDB broadcasts, registered locked_count.
module reg_status_file
    import reg_status_file_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    reg_status_file_if.slave   bus_s
);
    data_t  reg_data   [REG_NUM];
    lock_t  reg_lock   [REG_NUM];
    lock_t  reg_lock_d [REG_NUM];
    addr_t  rd_addr    [2];
    data_t  rd_data    [2];
    lock_t  rd_lock    [2];
    count_t count_q, count_d;

    // x0 is hard-wired: never locked, always zero.
    assign reg_data[0]   = '0;
    assign reg_lock[0]   = REG_NO_LOCK;
    assign reg_lock_d[0] = REG_NO_LOCK;

    for (genvar r = 1; r < REG_NUM; r++) begin : g_reg
        reg_status_file_cell u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .lock_set_i (bus_s.lock_enable && bus_s.lock_addr == addr_t'(r)),
            .lock_tag_i (bus_s.lock_tag),
            .alu_tag_i  (bus_s.cdb_in_index_alu),
            .alu_data_i (bus_s.cdb_in_result_alu),
            .lsm_tag_i  (bus_s.cdb_in_index_lsm),
            .lsm_data_i (bus_s.cdb_in_result_lsm),
            .data_o     (reg_data[r]),
            .lock_o     (reg_lock[r]),
            .lock_d_o   (reg_lock_d[r])
        );
    end

    assign rd_addr[0] = bus_s.rd_addr1;
    assign rd_addr[1] = bus_s.rd_addr2;

    // Reads see the stored lock only (a same-cycle claim is invisible), but a
    // live broadcast matching that lock is forwarded so issue never misses it.
    for (genvar p = 0; p < 2; p++) begin : g_rd
        lock_t l;
        logic  byp_alu, byp_lsm;
        assign l          = reg_lock[rd_addr[p]];
        assign byp_alu    = is_live(bus_s.cdb_in_index_alu) && l == bus_s.cdb_in_index_alu;
        assign byp_lsm    = is_live(bus_s.cdb_in_index_lsm) && l == bus_s.cdb_in_index_lsm;
        assign rd_data[p] = byp_alu ? bus_s.cdb_in_result_alu :
                            byp_lsm ? bus_s.cdb_in_result_lsm : reg_data[rd_addr[p]];
        assign rd_lock[p] = (byp_alu || byp_lsm) ? REG_NO_LOCK : l;
    end

    assign bus_s.rd_data1 = rd_data[0];
    assign bus_s.rd_lock1 = rd_lock[0];
    assign bus_s.rd_data2 = rd_data[1];
    assign bus_s.rd_lock2 = rd_lock[1];

    always_comb begin
        count_d = '0;
        for (int i = 0; i < REG_NUM; i++)
            count_d = count_d + count_t'(reg_lock_d[i] != REG_NO_LOCK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign bus_s.locked_count = count_q;
endmodule

// File: tb/tb_reg_status_file.sv
// tb_reg_status_file: directed scoreboard bench for reg_status_file.
module tb_reg_status_file;
    import reg_status_file_pkg::*;

    localparam lock_t NL = REG_NO_LOCK;

    typedef struct {
        string  name;
        data_t  d1;
        lock_t  l1;
        data_t  d2;
        lock_t  l2;
        count_t cnt;
    } exp_t;

    logic clk = 0;
    logic rst_n = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    reg_status_file_if bus();

    reg_status_file dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_s (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, string field, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s got %0h expected %0h", name, field, act, req);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    initial forever begin
        @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "d1",  32'(bus.rd_data1),     32'(e.d1));
            chk(e.name, "l1",  32'(bus.rd_lock1),     32'(e.l1));
            chk(e.name, "d2",  32'(bus.rd_data2),     32'(e.d2));
            chk(e.name, "l2",  32'(bus.rd_lock2),     32'(e.l2));
            chk(e.name, "cnt", 32'(bus.locked_count), 32'(e.cnt));
        end
    end

    task automatic drive(logic le, addr_t la, lock_t lt, lock_t ai, data_t ar,
                         lock_t li, data_t lr, addr_t a1, addr_t a2);
        bus.lock_enable       = le;
        bus.lock_addr         = la;
        bus.lock_tag          = lt;
        bus.cdb_in_index_alu  = ai;
        bus.cdb_in_result_alu = ar;
        bus.cdb_in_index_lsm  = li;
        bus.cdb_in_result_lsm = lr;
        bus.rd_addr1          = a1;
        bus.rd_addr2          = a2;
    endtask

    task automatic expect_now(string name, data_t d1, lock_t l1, data_t d2, lock_t l2, count_t cnt);
        exp_t e;
        e.name = name; e.d1 = d1; e.l1 = l1; e.d2 = d2; e.l2 = l2; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic cyc(string name, logic le, addr_t la, lock_t lt, lock_t ai, data_t ar,
                       lock_t li, data_t lr, addr_t a1, addr_t a2,
                       data_t d1, lock_t l1, data_t d2, lock_t l2, count_t cnt);
        @(posedge clk);
        #1;
        drive(le, la, lt, ai, ar, li, lr, a1, a2);
        expect_now(name, d1, l1, d2, l2, cnt);
    endtask

    initial begin
        drive(0, 0, 0, NL, 0, NL, 0, 3, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        expect_now("reset_x3_x0", 0, NL, 0, NL, 0);
        //   name            le la lt ai  ar        li  lr     a1 a2  d1        l1  d2       l2  cnt
        cyc("lock_x5_hidden", 1, 5, 2, NL, 0,        NL, 0,     5, 3,  0,        NL, 0,       NL, 0);
        cyc("x5_locked",      0, 0, 0, NL, 0,        NL, 0,     5, 3,  0,        2,  0,       NL, 1);
        cyc("x5_alu_bypass",  0, 0, 0, 2,  'h1234,   NL, 0,     5, 3,  'h1234,   NL, 0,       NL, 1);
        cyc("x5_captured",    0, 0, 0, NL, 0,        NL, 0,     5, 3,  'h1234,   NL, 0,       NL, 0);
        cyc("lock_x7_t1",     1, 7, 1, NL, 0,        NL, 0,     7, 5,  0,        NL, 'h1234,  NL, 0);
        cyc("x7_relock_lsm",  1, 7, 3, NL, 0,        1,  'hAA,  7, 5,  'hAA,     NL, 'h1234,  NL, 1);
        cyc("x7_lock_wins",   0, 0, 0, NL, 0,        NL, 0,     7, 0,  'hAA,     3,  0,       NL, 1);
        cyc("lock_x0",        1, 0, 4, NL, 0,        NL, 0,     0, 7,  0,        NL, 'hAA,    3,  1);
        cyc("x0_ignored",     0, 0, 0, NL, 0,        NL, 0,     0, 7,  0,        NL, 'hAA,    3,  1);
        cyc("lock_x9_t2",     1, 9, 2, NL, 0,        NL, 0,     9, 0,  0,        NL, 0,       NL, 1);
        cyc("relock_x9_t5",   1, 9, 5, NL, 0,        NL, 0,     9, 0,  0,        2,  0,       NL, 2);
        cyc("x9_stale_alu",   0, 0, 0, 2,  7,        NL, 0,     9, 5,  0,        5,  'h1234,  NL, 2);
        cyc("x9_unchanged",   0, 0, 0, NL, 0,        NL, 0,     9, 7,  0,        5,  'hAA,    3,  2);
        cyc("alu_beats_lsm",  0, 0, 0, 5,  'h55,     5,  'h66,  9, 7,  'h55,     NL, 'hAA,    3,  2);
        cyc("x9_alu_stored",  0, 0, 0, NL, 0,        NL, 0,     9, 7,  'h55,     NL, 'hAA,    3,  1);
        cyc("lock_x4_t1",     1, 4, 1, NL, 0,        NL, 0,     4, 6,  0,        NL, 0,       NL, 1);
        cyc("lock_x6_t6",     1, 6, 6, NL, 0,        NL, 0,     4, 6,  0,        1,  0,       NL, 2);
        cyc("x4_x6_locked",   0, 0, 0, NL, 0,        NL, 0,     6, 4,  0,        6,  0,       1,  3);
        // Reset asserted mid-cycle with a live broadcast in flight; checked before the next edge.
        @(posedge clk);
        #1 drive(0, 0, 0, 3, 'hDEAD, NL, 0, 7, 6);
        #2 rst_n = 0;
        expect_now("async_reset", 0, NL, 0, NL, 0);
        @(posedge clk);
        #1 rst_n = 1;
        drive(0, 0, 0, NL, 0, NL, 0, 5, 4);
        expect_now("after_reset", 0, NL, 0, NL, 0);
        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
